o_feature_drain: RTL

- Read side of the per-lane output-feature FIFO bank: `o_feature_reg` owns the write side.
- Pulls one feature word per read from the Tm lane FIFOs in channel-interleaved order.
- Packs PACK words into one wide beat and presents it on a valid/ready stream toward the write-back/DDR path.
- Sequences one output tile per `start`; signals `done` when the tile has fully left the block.

---
 rtl/o_feature_pkg.sv | 10 +
 rtl/o_feature_drain_packer.sv | 59 +++++
 rtl/o_feature_drain.sv | 71 +++++++
 3 files changed

// File: rtl/o_feature_pkg.sv
// o_feature_pkg: shared FSM encoding and pack-width helpers for the output-feature drain
package o_feature_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  function automatic int pack_of(input int out_w, input int feat_w);
    return out_w / feat_w;
  endfunction
  function automatic bit width_ok(input int out_w, input int feat_w);
    return feat_w > 0 && out_w >= feat_w && out_w % feat_w == 0;
  endfunction
endpackage

// File: rtl/o_feature_drain_packer.sv
// feature_packer: gathers feature words into PACK-slot beats held on a valid/ready output register
module feature_packer
  import o_feature_pkg::*;
#(
  parameter int FEATURE_WIDTH = 16,
  parameter int OUT_WIDTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic rd,
  input  logic flush,
  input  logic [FEATURE_WIDTH-1:0] rd_data,
  input  logic out_ready,
  output logic slot_free,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic out_valid,
  output logic out_last
);
  localparam int PACK = pack_of(OUT_WIDTH, FEATURE_WIDTH);
  localparam int PW = $clog2(PACK + 1);
  logic [PACK-1:0][FEATURE_WIDTH-1:0] slots, slots_n;
  logic [PW-1:0] pack_cnt, cnt_n;
  logic cap, out_free, emit;
  always_comb begin
    slots_n = slots;
    for (int i = 0; i < PACK; i++)
      if (cap && PW'(i) == pack_cnt) slots_n[i] = rd_data;
    cnt_n = pack_cnt + PW'(cap);
    out_free = !out_valid || out_ready;
    emit = out_free && (cnt_n == PW'(PACK) || (flush && cnt_n != '0));
  end
  // slots are cleared on every emit, so a partial final beat is already zero-padded
  assign slot_free = (pack_cnt + PW'(cap) < PW'(PACK)) || out_free;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cap <= 1'b0;
      pack_cnt <= '0;
      slots <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else begin
      cap <= rd;
      if (emit) begin
        out_data <= slots_n;
        out_valid <= 1'b1;
        out_last <= flush;
        slots <= '0;
        pack_cnt <= '0;
      end else begin
        slots <= slots_n;
        pack_cnt <= cnt_n;
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end
      end
    end
endmodule

// File: rtl/o_feature_drain.sv
// o_feature_drain: reads lane FIFOs in channel-interleaved order and streams packed beats per tile
module o_feature_drain
  import o_feature_pkg::*;
#(
  parameter int Tm = 8,
  parameter int FEATURE_WIDTH = 16,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [CNT_WIDTH-1:0] tile_len,
  input  logic [Tm-1:0] lane_empty,
  output logic [Tm-1:0] rd_feature_enable,
  input  logic [FEATURE_WIDTH-1:0] rd_feature_in,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic out_last,
  output logic busy,
  output logic done
);
  localparam int LW = Tm > 1 ? $clog2(Tm) : 1;
  if (!width_ok(OUT_WIDTH, FEATURE_WIDTH)) begin : g_bad_width
    $error("OUT_WIDTH must be a multiple of FEATURE_WIDTH");
  end
  state_t state, state_n;
  logic [LW-1:0] lane;
  logic [CNT_WIDTH-1:0] feat, len;
  logic slot_free, strobe, last_rd;
  // the lane index only advances on a strobe, so an empty lane stalls rather than being skipped
  assign strobe = state == RUN && !lane_empty[lane] && slot_free;
  assign last_rd = lane == LW'(Tm - 1) && feat == len - 1'b1;
  assign rd_feature_enable = strobe ? Tm'(1) << lane : '0;
  assign busy = state == RUN || state == FLUSH;
  assign done = state == DONE;
  always_comb
    state_n = state == IDLE  ? (start ? (tile_len != '0 ? RUN : DONE) : IDLE) :
              state == RUN   ? (strobe && last_rd ? FLUSH : RUN) :
              state == FLUSH ? (out_valid && out_ready && out_last ? DONE : FLUSH) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lane <= '0;
      feat <= '0;
      len <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        len <= tile_len;
        lane <= '0;
        feat <= '0;
      end else if (strobe) begin
        lane <= lane == LW'(Tm - 1) ? '0 : lane + 1'b1;
        if (lane == LW'(Tm - 1)) feat <= feat + 1'b1;
      end
    end
  feature_packer #(.FEATURE_WIDTH(FEATURE_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_packer (
    .clk(clk),
    .rst(rst),
    .rd(strobe),
    .flush(state == FLUSH),
    .rd_data(rd_feature_in),
    .out_ready(out_ready),
    .slot_free(slot_free),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last)
  );
endmodule
